regfile_wb: RTL and testbench

Register file with an integrated write-back stage for the 8-bit datapath. Its two combinational read ports drive the ALU operand inputs (r0, r1). The ALU result and zero indication come back through a one-entry write-back pipeline register. That pending entry is forwarded to the read ports until it is committed to the storage array. The block also holds the architectural zero flag used by branch logic.

---
 rtl/regfile_wb_if.sv | 32 +++
 rtl/regfile_wb.sv | 79 +++++++
 tb/tb_regfile_wb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Operand read and write-back bus of the 8-bit register file.
// wb_valid has no ready: every write-back presented with wb_valid is accepted at that clock edge.
interface regfile_wb_if #(
    parameter int NREGS = 8,
    parameter int W     = 8
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [W-1:0]  rd_data_a;
    logic [W-1:0]  rd_data_b;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          wb_zero;
    logic          wb_setflag;
    logic          zero_flag;
    logic          pend_valid;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wb_valid, wb_addr, wb_data, wb_zero, wb_setflag,
        input  rd_data_a, rd_data_b, zero_flag, pend_valid
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wb_valid, wb_addr, wb_data, wb_zero, wb_setflag,
        output rd_data_a, rd_data_b, zero_flag, pend_valid
    );
endinterface

// File: rtl/regfile_wb.sv
// Register file with a one-entry write-back stage; the pending entry is forwarded
// to both combinational read ports until it commits to the array on the next edge.
module regfile_wb #(
    parameter int NREGS = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [W-1:0]  mem_q [NREGS];
    logic [W-1:0]  mem_d [NREGS];
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q,  pend_addr_d;
    logic [W-1:0]  pend_data_q,  pend_data_d;
    logic          zero_flag_q,  zero_flag_d;

    // The older pending entry commits on the same edge a newer one is captured,
    // so back-to-back writes to any address are never dropped.
    always_comb begin
        mem_d = mem_q;
        if (pend_valid_q) begin
            mem_d[pend_addr_q] = pend_data_q;
        end
    end

    always_comb begin
        pend_valid_d = bus.wb_valid;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        zero_flag_d  = zero_flag_q;
        if (bus.wb_valid) begin
            pend_addr_d = bus.wb_addr;
            pend_data_d = bus.wb_data;
            if (bus.wb_setflag) begin
                zero_flag_d = bus.wb_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            zero_flag_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            zero_flag_q  <= zero_flag_d;
        end
    end

    // Only the registered pending entry is forwarded; wb_data never reaches the
    // read ports, which keeps ALU -> wb_data -> rd_data -> ALU free of a comb loop.
    always_comb begin
        bus.rd_data_a = mem_q[bus.rd_addr_a];
        bus.rd_data_b = mem_q[bus.rd_addr_b];
        if (pend_valid_q && (pend_addr_q == bus.rd_addr_a)) begin
            bus.rd_data_a = pend_data_q;
        end
        if (pend_valid_q && (pend_addr_q == bus.rd_addr_b)) begin
            bus.rd_data_b = pend_data_q;
        end
    end

    assign bus.zero_flag  = zero_flag_q;
    assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and random checks of regfile_wb against an architectural model in
// which a write becomes visible in the cycle after its clock edge.
module tb_regfile_wb;
    localparam int NREGS = 8;
    localparam int W     = 8;

    logic clk;
    logic reset;

    regfile_wb_if #(.NREGS(NREGS), .W(W)) bus ();

    regfile_wb #(.NREGS(NREGS), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [W-1:0] ref_mem [NREGS];
    logic         ref_pend;
    logic         ref_flag;

    // Advance one cycle, applying the architectural effect of the edge to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
            ref_pend = 1'b0;
            ref_flag = 1'b0;
        end else begin
            ref_pend = bus.wb_valid;
            if (bus.wb_valid) begin
                ref_mem[bus.wb_addr] = bus.wb_data;
                if (bus.wb_setflag) ref_flag = bus.wb_zero;
            end
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: got %h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic drive_wb(input logic v, input logic [2:0] a, input logic [W-1:0] d,
                            input logic z, input logic sf);
        bus.wb_valid   = v;
        bus.wb_addr    = a;
        bus.wb_data    = d;
        bus.wb_zero    = z;
        bus.wb_setflag = sf;
    endtask

    task automatic set_rd(input logic [2:0] a, input logic [2:0] b);
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        #1;
    endtask

    logic [W-1:0] sum;

    initial begin
        reset = 1'b1;
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state on every address of both ports
        for (int i = 0; i < NREGS; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            set_rd(3'(i), 3'(NREGS - 1 - i));
            chk("reset_rd_a", bus.rd_data_a);
            chk("reset_rd_b", bus.rd_data_b);
            tick();
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        chk("reset_flag", {7'd0, bus.zero_flag});
        chk("reset_pend", {7'd0, bus.pend_valid});

        // Single write r3 = A5: old value, forwarded, then from array
        drive_wb(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        set_rd(3'd3, 3'd0);
        chk("wr_cycle_n", bus.rd_data_a);
        tick();
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("wr_fwd", bus.rd_data_a);
        chk("wr_fwd_pend", {7'd0, bus.pend_valid});
        tick();
        chk("wr_array", bus.rd_data_a);
        chk("wr_array_pend", {7'd0, bus.pend_valid});

        // Back-to-back writes to the same register
        drive_wb(1'b1, 3'd2, 8'h11, 1'b0, 1'b0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h22);
        tick();
        drive_wb(1'b1, 3'd2, 8'h22, 1'b0, 1'b0);
        set_rd(3'd2, 3'd2);
        chk("b2b_first_a", bus.rd_data_a);
        chk("b2b_first_b", bus.rd_data_b);
        tick();
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("b2b_second_a", bus.rd_data_a);
        chk("b2b_second_b", bus.rd_data_b);
        tick();
        chk("b2b_array_a", bus.rd_data_a);
        chk("b2b_array_b", bus.rd_data_b);

        // Back-to-back writes to different registers both persist
        drive_wb(1'b1, 3'd5, 8'h7F, 1'b0, 1'b0);
        tick();
        drive_wb(1'b1, 3'd6, 8'h80, 1'b0, 1'b0);
        tick();
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h80);
        set_rd(3'd5, 3'd6);
        chk("persist_r5", bus.rd_data_a);
        chk("persist_r6", bus.rd_data_b);

        // Zero flag set, held without setflag, held when setflag lacks wb_valid
        drive_wb(1'b1, 3'd7, 8'h00, 1'b1, 1'b1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        tick();
        chk("flag_set", {7'd0, bus.zero_flag});
        drive_wb(1'b1, 3'd7, 8'h01, 1'b0, 1'b0);
        tick();
        chk("flag_no_setflag", {7'd0, bus.zero_flag});
        drive_wb(1'b0, 3'd7, 8'h02, 1'b0, 1'b1);
        tick();
        chk("flag_no_valid", {7'd0, bus.zero_flag});

        // Reset dominates a new write and discards the pending one
        drive_wb(1'b1, 3'd4, 8'h33, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive_wb(1'b1, 3'd1, 8'hFF, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        set_rd(3'd1, 3'd4);
        chk("rst_pend", {7'd0, bus.pend_valid});
        chk("rst_flag", {7'd0, bus.zero_flag});
        chk("rst_r1", bus.rd_data_a);
        chk("rst_r4", bus.rd_data_b);
        tick();
        chk("rst_r1_later", bus.rd_data_a);
        chk("rst_r4_later", bus.rd_data_b);

        // Closed loop with an add ALU: 01 + FF -> 00 into r0, then r0 + r1 -> FF
        drive_wb(1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
        tick();
        drive_wb(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        tick();
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        set_rd(3'd0, 3'd1);
        chk("alu_r0_in", bus.rd_data_a);
        chk("alu_r1_in", bus.rd_data_b);
        sum = bus.rd_data_a + bus.rd_data_b;
        drive_wb(1'b1, 3'd0, sum, (sum == 8'h00), 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        tick();
        drive_wb(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("alu_r0_result", bus.rd_data_a);
        chk("alu_zero_flag", {7'd0, bus.zero_flag});
        tick();
        sum = bus.rd_data_a + bus.rd_data_b;
        chk("alu_second_add", sum);

        // Random traffic against the architectural model
        for (int c = 0; c < 60; c++) begin
            drive_wb(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, NREGS - 1)),
                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            exp_q.push_back(ref_mem[bus.rd_addr_a]);
            set_rd(3'($urandom_range(0, NREGS - 1)), 3'($urandom_range(0, NREGS - 1)));
            exp_q.pop_back();
            exp_q.push_back(ref_mem[bus.rd_addr_a]);
            exp_q.push_back(ref_mem[bus.rd_addr_b]);
            exp_q.push_back({7'd0, ref_flag});
            exp_q.push_back({7'd0, ref_pend});
            chk("rand_rd_a", bus.rd_data_a);
            chk("rand_rd_b", bus.rd_data_b);
            chk("rand_flag", {7'd0, bus.zero_flag});
            chk("rand_pend", {7'd0, bus.pend_valid});
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
